// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  // MSB index of a PC or instruction word (32-bit, word-addressed PC).
  localparam int FETCH_WIDTH = 31;

  // Default number of fetch queue entries.
  localparam int FETCH_DEPTH = 4;

  // Canonical no-op encoding (addi x0, x0, 0), handy as filler data.
  localparam logic [FETCH_WIDTH:0] INSTR_NOP = 32'h00000013;

  // One fetched instruction as presented to decode.
  typedef struct packed {
    logic [FETCH_WIDTH:0] pc;
    logic [FETCH_WIDTH:0] instr;
    logic                 predicted;
  } fetch_entry_t;

  // Bundle a returned instruction word with the PC and prediction flag that requested it.
  function automatic fetch_entry_t make_entry(
    input logic [FETCH_WIDTH:0] pc,
    input logic [FETCH_WIDTH:0] instr,
    input logic                 predicted
  );
    fetch_entry_t e;
    e.pc        = pc;
    e.instr     = instr;
    e.predicted = predicted;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, flush and occupancy count.
// The head entry is visible combinationally; a push is never bypassed to the head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic [PTRW:0] count,
  output logic         empty
);

  localparam logic [PTRW:0] DEPTH_CNT = (PTRW+1)'(DEPTH);

  logic [PTRW-1:0] head_reg;
  logic [PTRW-1:0] tail_reg;
  logic [PTRW:0]   count_reg;
  logic [PTRW:0]   count_next;
  logic            do_push;
  logic            do_pop;
  fetch_entry_t    slot_data [DEPTH];

  // Flush kills both directions; a full queue refuses a push and an empty one a pop.
  assign do_push = push & ~flush & (count_reg != DEPTH_CNT);
  assign do_pop  = pop  & ~flush & (count_reg != '0);

  // One register per slot; only the slot under the tail pointer captures a push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    fetch_entry_t slot_reg;

    // Capture push data into this slot when the tail points here.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (do_push && (tail_reg == PTRW'(gi))) begin
        slot_reg <= push_data;
      end
    end

    assign slot_data[gi] = slot_reg;
  end

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    count_next = count_reg;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (PTRW+1)'(1);
      2'b01:   count_next = count_reg - (PTRW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers and count; flush empties the queue without touching slot contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        tail_reg <= tail_reg + PTRW'(1);
      end
      if (do_pop) begin
        head_reg <= head_reg + PTRW'(1);
      end
      count_reg <= count_next;
    end
  end

  assign head_data = slot_data[head_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues nextPC to a 1-cycle synchronous instruction
// memory, pairs the returned word with its PC and prediction flag, and buffers
// the result for decode. Freeze is credit based so the queue never overflows.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FETCH_WIDTH,
  parameter int DEPTH = FETCH_DEPTH,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           globalResetN,
  input  logic [WIDTH:0] nextPC,
  input  logic           redirect,
  input  logic           flush,
  output logic [WIDTH:0] imemAddr,
  output logic           imemRe,
  input  logic [WIDTH:0] imemData,
  output logic           fetchFreeze,
  output logic           decValid,
  input  logic           decReady,
  output logic [WIDTH:0] decPC,
  output logic [WIDTH:0] decInstr,
  output logic           decPredicted
);

  // Credits are counted one bit wider than the queue count so the sum cannot wrap.
  localparam logic [PTRW+1:0] CREDIT_LIMIT = (PTRW+2)'(DEPTH);

  logic           req_valid_reg;
  logic [WIDTH:0] req_pc_reg;
  logic           req_redirect_reg;

  logic [PTRW:0]   fifo_count;
  logic            fifo_empty;
  logic [PTRW+1:0] credit;
  logic            enq;
  logic            deq;
  fetch_entry_t    enq_entry;
  fetch_entry_t    head_entry;

  // Entries already buffered plus the one in flight; a same-cycle dequeue is
  // deliberately ignored so the in-flight word always has a free slot.
  assign credit      = {1'b0, fifo_count} + {{(PTRW+1){1'b0}}, req_valid_reg};
  assign fetchFreeze = (credit >= CREDIT_LIMIT);

  // No issue during reset, during a flush (nextPC is stale) or while out of credit.
  assign imemRe   = globalResetN & ~flush & ~fetchFreeze;
  assign imemAddr = nextPC;

  // Remember what was issued so the word returning next cycle can be tagged.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      req_valid_reg    <= 1'b0;
      req_pc_reg       <= '0;
      req_redirect_reg <= 1'b0;
    end else begin
      req_valid_reg <= imemRe & ~flush;
      if (imemRe) begin
        req_pc_reg       <= nextPC;
        req_redirect_reg <= redirect;
      end
    end
  end

  // A word returning in a flush cycle belongs to the discarded path.
  assign enq       = req_valid_reg & ~flush;
  assign deq       = decValid & decReady;
  assign enq_entry = make_entry(req_pc_reg, imemData, req_redirect_reg);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (globalResetN),
    .flush     (flush),
    .push      (enq),
    .push_data (enq_entry),
    .pop       (deq),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign decValid     = ~fifo_empty;
  assign decPC        = head_entry.pc;
  assign decInstr     = head_entry.instr;
  assign decPredicted = head_entry.predicted;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven backpressure vectors,
// hand-written corner sequences and a running scoreboard of issued PCs.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int W = FETCH_WIDTH;
  localparam int D = FETCH_DEPTH;

  logic         clk = 1'b0;
  logic         globalResetN;
  logic [W:0]   nextPC;
  logic         redirect;
  logic         flush;
  logic [W:0]   imemAddr;
  logic         imemRe;
  logic [W:0]   imemData;
  logic         fetchFreeze;
  logic         decValid;
  logic         decReady;
  logic [W:0]   decPC;
  logic [W:0]   decInstr;
  logic         decPredicted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .globalResetN (globalResetN),
    .nextPC       (nextPC),
    .redirect     (redirect),
    .flush        (flush),
    .imemAddr     (imemAddr),
    .imemRe       (imemRe),
    .imemData     (imemData),
    .fetchFreeze  (fetchFreeze),
    .decValid     (decValid),
    .decReady     (decReady),
    .decPC        (decPC),
    .decInstr     (decInstr),
    .decPredicted (decPredicted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word = address + 0x100, NOP when not read.
  always @(posedge clk) begin
    if (imemRe) imemData <= imemAddr + 32'h100;
    else        imemData <= INSTR_NOP;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W:0] pc;
    logic [W:0] instr;
    logic       pred;
  } exp_t;

  exp_t       exp_q[$];
  bit         mon_en     = 1'b0;
  bit         inflight   = 1'b0;
  bit         will_issue = 1'b0;
  int         pop_count  = 0;
  int         pred_count = 0;
  logic [W:0] pred_pc    = '0;

  // Every negedge: check handshake outputs against the model, retire a
  // dequeued entry, and push the PC that is about to be issued.
  always @(negedge clk) begin
    int   buffered;
    bit   exp_freeze;
    bit   exp_re;
    exp_t e;
    if (mon_en) begin
      if (!globalResetN) begin
        chk("rst_decValid", decValid, 0);
        chk("rst_imemRe", imemRe, 0);
        chk("rst_fetchFreeze", fetchFreeze, 0);
        exp_q.delete();
        inflight   = 1'b0;
        will_issue = 1'b0;
      end else begin
        buffered   = exp_q.size() - int'(inflight);
        exp_freeze = (buffered + int'(inflight)) >= D;
        exp_re     = !flush && !exp_freeze;
        chk("sb_decValid", decValid, buffered != 0);
        chk("sb_fetchFreeze", fetchFreeze, exp_freeze);
        chk("sb_imemRe", imemRe, exp_re);
        chk("sb_imemAddr", imemAddr, nextPC);
        if (flush) begin
          exp_q.delete();
          inflight   = 1'b0;
          will_issue = 1'b0;
        end else begin
          if (decReady && buffered != 0) begin
            e = exp_q.pop_front();
            chk("sb_decPC", decPC, e.pc);
            chk("sb_decInstr", decInstr, e.instr);
            chk("sb_decPredicted", decPredicted, e.pred);
            pop_count++;
            if (decPredicted) begin
              pred_count++;
              pred_pc = decPC;
            end
          end
          if (exp_re) exp_q.push_back('{pc: nextPC, instr: nextPC + 32'h100, pred: redirect});
          inflight   = exp_re;
          will_issue = imemRe;
        end
      end
    end
  end

  // ---------------- PC select model ----------------
  task automatic set_pc(input logic [W:0] pc);
    nextPC   = pc;
    redirect = (pc == 32'h20);
  endtask

  // Advance one cycle; nextPC moves on only if the previous PC was issued.
  task automatic step();
    @(posedge clk);
    #1;
    if (will_issue) set_pc(nextPC + 32'd1);
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    while (!decValid && n < max_cycles) begin
      step();
      #3;
      n++;
    end
    chk({name, "_timeout"}, decValid, 1);
  endtask

  typedef struct {
    logic       dec_ready;
    logic       exp_valid;
    logic       exp_freeze;
    logic       exp_re;
    logic [W:0] exp_pc;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd4};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd5};

    globalResetN = 1'b1;
    set_pc(32'd0);
    flush    = 1'b0;
    decReady = 1'b0;
    #2 globalResetN = 1'b0;
    #1;
    chk("reset_decValid", decValid, 0);
    chk("reset_imemRe", imemRe, 0);
    chk("reset_fetchFreeze", fetchFreeze, 0);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // Backpressure then drain, one table row per cycle after reset release.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        @(posedge clk);
        #1;
        globalResetN = 1'b1;
        set_pc(32'd0);
      end else begin
        step();
      end
      decReady = tbl[i].dec_ready;
      #3;
      chk($sformatf("tbl%0d_decValid", i), decValid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_fetchFreeze", i), fetchFreeze, tbl[i].exp_freeze);
      chk($sformatf("tbl%0d_imemRe", i), imemRe, tbl[i].exp_re);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_decPC", i), decPC, tbl[i].exp_pc);
    end

    // Streaming from PC 0 with decode always ready.
    step(); flush = 1'b1; decReady = 1'b1;
    step(); flush = 1'b0; set_pc(32'd0);
    #3 chk("stream_c0_imemRe", imemRe, 1);
    step(); #3 chk("stream_c1_decValid", decValid, 0);
    step(); #3 chk("stream_c2_decValid", decValid, 1);
    chk("stream_c2_decPC", decPC, 32'd0);
    chk("stream_c2_decInstr", decInstr, 32'h100);
    step(); #3 chk("stream_c3_decPC", decPC, 32'd1);
    chk("stream_c3_fetchFreeze", fetchFreeze, 0);
    step(); #3 chk("stream_c4_decPC", decPC, 32'd2);
    step(); #3 chk("stream_c5_decPC", decPC, 32'd3);
    chk("stream_c5_decInstr", decInstr, 32'h103);

    // Flush with three entries queued and one word in flight.
    step(); flush = 1'b1; decReady = 1'b0;
    step(); flush = 1'b0; set_pc(32'h10);
    step(); step(); step();
    step();
    #3;
    chk("flush_pre_freeze", fetchFreeze, 1);
    chk("flush_pre_decPC", decPC, 32'h10);
    flush = 1'b1;
    step(); flush = 1'b0; set_pc(32'h40);
    #3;
    chk("flush_post_decValid", decValid, 0);
    chk("flush_post_imemRe", imemRe, 1);
    decReady = 1'b1;
    wait_valid("flush_restart", 8);
    chk("flush_restart_decPC", decPC, 32'h40);
    chk("flush_restart_decInstr", decInstr, 32'h140);

    // Prediction flag rides with PC 0x20 only.
    step(); flush = 1'b1;
    step(); flush = 1'b0; set_pc(32'h1E);
    pred_count = 0;
    repeat (10) step();
    chk("pred_count", pred_count, 1);
    chk("pred_pc", pred_pc, 32'h20);

    // Wrap-around with decode toggling every cycle.
    step(); flush = 1'b1;
    step(); flush = 1'b0; set_pc(32'h50);
    pop_count = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      decReady = ~decReady;
    end
    chk("wrap_pops_ge_10", pop_count >= 10, 1);

    // Asynchronous reset in the middle of a stream.
    decReady = 1'b1;
    step(); flush = 1'b1;
    step(); flush = 1'b0; set_pc(32'h60);
    repeat (4) step();
    #2;
    chk("arst_pre_decValid", decValid, 1);
    globalResetN = 1'b0;
    #1;
    chk("arst_decValid", decValid, 0);
    chk("arst_imemRe", imemRe, 0);
    chk("arst_fetchFreeze", fetchFreeze, 0);
    repeat (2) step();
    set_pc(32'h80);
    globalResetN = 1'b1;
    wait_valid("arst_restart", 8);
    chk("arst_restart_decPC", decPC, 32'h80);
    chk("arst_restart_decInstr", decInstr, 32'h180);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly downstream of the PC select register.
- Each cycle it issues the registered nextPC to a synchronous instruction memory (1-cycle read latency).
- It pairs the returned instruction word with its PC and prediction flag, and buffers the result in a small circular queue that feeds decode.
- It generates the fetch-side freeze contribution back to PC select, and discards all in-flight and buffered work on a flush (ROB reset or early misdirect).

Parameters:
- WIDTH, 31, MSB index of PC and instruction (32-bit, word-addressed PC).
- DEPTH, 4, fetch queue entries; power of two, at least 2.
- PTRW, $clog2(DEPTH), queue pointer width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- globalResetN  input  1  asynchronous active-low reset.
- nextPC  input  WIDTH+1  registered PC from PC select.
- redirect  input  1  nextPC was produced from a predictor hit.
- flush  input  1  reset | earlyMisdirect from the pipeline; kills all fetch work.
- imemAddr  output  WIDTH+1  instruction memory address (= nextPC).
- imemRe  output  1  instruction memory read enable.
- imemData  input  WIDTH+1  instruction word, valid the cycle after imemRe.
- fetchFreeze  output  1  queue cannot accept another fetch; ORed into PC select freeze.
- decValid  output  1  head entry valid.
- decReady  input  1  decode accepts head entry.
- decPC  output  WIDTH+1  PC of head entry.
- decInstr  output  WIDTH+1  instruction of head entry.
- decPredicted  output  1  redirect flag of head entry.

Behaviour:
- Reset (globalResetN=0, async): count, head and tail pointers, reqValid, reqPC and reqRedirect clear to 0; queue storage clears to 0.
  - Outputs while in reset: decValid=0, fetchFreeze=0, imemRe=0.
- Issue (combinational): imemRe = globalResetN & !flush & !fetchFreeze; imemAddr = nextPC.
- Request register (posedge):
  - reqValid <= imemRe.
  - reqPC <= nextPC and reqRedirect <= redirect when imemRe=1.
- Enqueue (posedge): if reqValid & !flush, write {reqPC, imemData, reqRedirect} at tail; tail <= tail+1 (mod DEPTH).
- Dequeue (posedge): if decValid & decReady & !flush, head <= head+1 (mod DEPTH).
- count update: +1 on enqueue only, -1 on dequeue only, unchanged when both occur.
- decValid = (count != 0); decPC, decInstr and decPredicted read the head entry combinationally, with no bypass.
- Latency: PC issued in cycle N, enqueued at the end of N+1, decValid=1 in N+2 at the earliest.
- fetchFreeze = (count + reqValid >= DEPTH). This is a conservative credit rule that ignores a same-cycle dequeue, so enqueue can never overflow.
  - While frozen, PC select holds nextPC and the same PC is reissued once freeze drops; no PC is lost or duplicated.
- Flush (synchronous, highest priority):
  - count, head and tail <= 0; reqValid <= 0.
  - Returning imemData that cycle is discarded, and no issue occurs in the flush cycle because nextPC is stale.
  - The first post-flush PC issues in the following cycle.
- Full with simultaneous enqueue and dequeue: legal only if count < DEPTH, which the credit rule guarantees; count unchanged.
- Empty with decReady=1: no dequeue; pointers unchanged.
- Wrap-around: pointers wrap modulo DEPTH with no bubble.
- Reset asserted mid-operation: all state is discarded immediately; the bench must tolerate imemData arriving while in reset.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t packed struct {pc, instr, predicted}.
  - FETCH_DEPTH constant.
  - INSTR_NOP constant (32'h00000013), used for unused-storage checks.
- One sub-module, fetch_fifo: generic fetch_entry_t circular buffer with push/pop/flush/count.
- fetch_queue contains the request register, the credit/freeze logic and the fetch_fifo instance.

Test Plan:
- Streaming: nextPC 0,1,2,3 with decReady=1 and imemData=PC+0x100 -> decValid from cycle 2; decPC 0,1,2,3 paired with decInstr 0x100..0x103; fetchFreeze stays 0.
- Backpressure: decReady=0, DEPTH=4 -> fetchFreeze rises when count+reqValid reaches 4 and exactly 4 entries are held. Raising decReady then drains PCs 0..3 in order, and PC 4 is issued once with no duplicate.
- Flush: 3 entries queued plus one in flight, then flush=1 for one cycle with nextPC=0x40 next cycle -> decValid=0 the cycle after flush; the next decPC is 0x40; the in-flight word never appears.
- Prediction flag: redirect=1 with nextPC=0x20 -> that entry has decPredicted=1; the neighbouring entries have 0.
- Wrap and concurrency: 10 fetches with decReady toggling every cycle -> order is preserved across pointer wrap, and count never exceeds 4 or underflows.
- Async reset: drop globalResetN mid-stream between clock edges -> decValid, imemRe and fetchFreeze go to 0 immediately. After release, the first fetch returns the new nextPC only.
